// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: access sizes,
// RV64 load/store funct3 encodings, opcodes and the responder FSM states.
package dmem_responder_pkg;

    // Load/store major opcodes
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } dmem_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } dmem_state_t;

    // Access size is carried in the low two funct3 bits for loads and stores
    function automatic dmem_size_t f3_size(input logic [2:0] f3);
        return dmem_size_t'(f3[1:0]);
    endfunction

    // Stores only define 0xx; loads reject 111 (no ldu in RV64)
    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        return write ? f3[2] : (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane logic: byte enables and write-data shift for stores,
// lane selection plus sign/zero extension for loads, natural-alignment check.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  dmem_size_t  size_i,
    input  logic [2:0]  offset_i,
    input  logic        sign_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  byte_en_o,
    output logic [63:0] wdata_sh_o,
    output logic [63:0] rdata_ext_o,
    output logic        misaligned_o
);

    logic [7:0]  base_en;
    logic [63:0] lanes;

    // Decode size into lane mask, alignment and load extension
    always_comb begin
        base_en      = 8'h00;
        misaligned_o = 1'b0;
        rdata_ext_o  = '0;
        lanes        = rdata_i >> {offset_i, 3'b000};
        wdata_sh_o   = wdata_i << {offset_i, 3'b000};
        case (size_i)
            BYTE: begin
                base_en     = 8'h01;
                rdata_ext_o = {{56{sign_i & lanes[7]}}, lanes[7:0]};
            end
            HALF: begin
                base_en      = 8'h03;
                misaligned_o = offset_i[0];
                rdata_ext_o  = {{48{sign_i & lanes[15]}}, lanes[15:0]};
            end
            WORD: begin
                base_en      = 8'h0F;
                misaligned_o = |offset_i[1:0];
                rdata_ext_o  = {{32{sign_i & lanes[31]}}, lanes[31:0]};
            end
            default: begin
                base_en      = 8'hFF;
                misaligned_o = |offset_i;
                rdata_ext_o  = lanes;
            end
        endcase
        byte_en_o = base_en << offset_i;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per valid/ready handshake,
// waits WAIT_CYCLES, performs one RAM access and holds the response until taken.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [63:0]       mem_q [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              out_of_range;
    logic              misaligned;
    logic              acc_err;
    logic              do_write;
    logic [7:0]        byte_en;
    logic [63:0]       wdata_sh;
    logic [63:0]       rdata_ext;

    assign idx          = addr_q[3 +: IDX_W];
    assign out_of_range = |(addr_q >> (IDX_W + 3));
    assign acc_err      = misaligned | out_of_range | f3_illegal(write_q, funct3_q);
    assign do_write     = (state_q == S_ACCESS) && write_q && !acc_err && !reset;

    dmem_lane_align u_align (
        .size_i       (f3_size(funct3_q)),
        .offset_i     (addr_q[2:0]),
        .sign_i       (!funct3_q[2]),
        .wdata_i      (wdata_q),
        .rdata_i      (mem_q[idx]),
        .byte_en_o    (byte_en),
        .wdata_sh_o   (wdata_sh),
        .rdata_ext_o  (rdata_ext),
        .misaligned_o (misaligned)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next-state, request latch, wait counter and response data
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = '0;
                    state_d  = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACCESS: begin
                err_d   = acc_err;
                rdata_d = (write_q || acc_err) ? '0 : rdata_ext;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Byte-masked RAM write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (byte_en[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule
